// File: rtl/masked_sq_scaler_pipe.sv
// masked_sq_scaler_pipe
//   Elastic, share-wise GF(2^2) square-scaler for the masked AES S-box tower-field datapath.
//   Every 2-bit lane of every DOM share is passed through one of four linear square-scale
//   maps selected by a runtime mode register, then carried through STAGES register stages
//   with per-stage valid bits and valid/ready backpressure.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   cfg_valid/ready mode update handshake; accepted only while the pipeline is empty
//   cfg_mode        requested map select
//   mode            current map select register
//   in_valid/ready  upstream handshake
//   in_data         share s in [2*LANES*(s+1)-1 : 2*LANES*s], lane l of a share in [2l+1:2l]
//   out_valid/ready downstream handshake
//   out_data        mapped data, same packing as in_data
//   xfer_cnt        wrapping count of completed output transfers
module masked_sq_scaler_pipe #(
   parameter int unsigned LANES  = 4,
   parameter int unsigned SHARES = 2,
   parameter int unsigned STAGES = 2,
   parameter int unsigned DW     = 2 * LANES * SHARES
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cfg_valid,
   input  logic [1:0]    cfg_mode,
   output logic          cfg_ready,
   output logic [1:0]    mode,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [15:0]   xfer_cnt
);

   // Square-scale map of one GF(2^2) lane a = (a1, a0).
   function automatic logic [1:0] sq_scale(input logic [1:0] a, input logic [1:0] m);
      logic [1:0] res;
      logic       s;
      s   = a[1] ^ a[0];
      res = 2'b00;
      unique case (m)
         2'd0: res = {s, a[0]};
         2'd1: res = {s, a[1]};
         2'd2: res = {a[0], s};
         2'd3: res = {a[1], s};
         default: res = 2'b00;
      endcase
      return res;
   endfunction

   // ------------------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------------------
   logic [1:0]        mode_q, mode_d;
   logic [15:0]       xfer_q, xfer_d;
   logic [STAGES-1:0] vld_q, vld_d;
   logic [DW-1:0]     data_q [STAGES];
   logic [DW-1:0]     data_d [STAGES];

   logic [DW-1:0]     mapped;
   logic [STAGES-1:0] stage_load;
   logic              cfg_fire;
   logic              in_fire;
   logic              out_fire;

   // ------------------------------------------------------------------------------------
   // Share-wise map. Each lane only sees its own two bits and the mode register, so no
   // output bit of one share ever depends on another share.
   // ------------------------------------------------------------------------------------
   for (genvar s = 0; s < SHARES; s++) begin : g_share
      for (genvar l = 0; l < LANES; l++) begin : g_lane
         localparam int unsigned Base = 2 * (LANES * s + l);
         assign mapped[Base +: 2] = sq_scale(in_data[Base +: 2], mode_q);
      end
   end

   // ------------------------------------------------------------------------------------
   // Stage load enables. Stage k may load when it is empty or the stage after it loads;
   // the last stage hands off when out_ready. Unrolled as a running OR from the output end
   // so that empty stages anywhere downstream let bubbles collapse.
   // ------------------------------------------------------------------------------------
   always_comb begin
      logic acc;
      acc        = out_ready;
      stage_load = '0;
      for (int k = int'(STAGES) - 1; k >= 0; k--) begin
         acc           = acc | ~vld_q[k];
         stage_load[k] = acc;
      end
   end

   // Handshakes. Gating with rst_n keeps both readies low while reset is asserted.
   assign cfg_ready = rst_n & ~(|vld_q) & ~in_valid;
   assign cfg_fire  = cfg_valid & cfg_ready;
   assign in_ready  = rst_n & stage_load[0] & ~cfg_fire;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = vld_q[STAGES-1] & out_ready;

   // ------------------------------------------------------------------------------------
   // Next state
   // ------------------------------------------------------------------------------------
   always_comb begin
      vld_d  = vld_q;
      data_d = data_q;

      // Stage 0 captures the mapped word under the mode in force at acceptance.
      if (stage_load[0]) begin
         vld_d[0] = in_fire;
         if (in_fire) begin
            data_d[0] = mapped;
         end
      end

      for (int k = 1; k < int'(STAGES); k++) begin
         if (stage_load[k]) begin
            vld_d[k] = vld_q[k-1];
            if (vld_q[k-1]) begin
               data_d[k] = data_q[k-1];
            end
         end
      end
   end

   always_comb begin
      mode_d = mode_q;
      if (cfg_fire) begin
         mode_d = cfg_mode;
      end
   end

   always_comb begin
      xfer_d = xfer_q;
      if (out_fire) begin
         xfer_d = xfer_q + 16'd1;
      end
   end

   // ------------------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q  <= '0;
         mode_q <= 2'd0;
         xfer_q <= 16'd0;
         for (int k = 0; k < int'(STAGES); k++) begin
            data_q[k] <= '0;
         end
      end else begin
         vld_q  <= vld_d;
         mode_q <= mode_d;
         xfer_q <= xfer_d;
         for (int k = 0; k < int'(STAGES); k++) begin
            data_q[k] <= data_d[k];
         end
      end
   end

   // Outputs come straight from the last stage registers.
   assign out_valid = vld_q[STAGES-1];
   assign out_data  = data_q[STAGES-1];
   assign mode      = mode_q;
   assign xfer_cnt  = xfer_q;

endmodule

// File: tb/tb_masked_sq_scaler_pipe.sv
`timescale 1ns/1ps
module tb_masked_sq_scaler_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cfg_valid = 1'b0;
   logic [1:0]  cfg_mode = 2'd0;
   logic        cfg_ready;
   logic [1:0]  mode;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_data = 16'h0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_data;
   logic [15:0] xfer_cnt;

   int total = 0;
   int bad   = 0;
   logic [1:0] cur_mode = 2'd0;

   masked_sq_scaler_pipe #(
      .LANES (4),
      .SHARES(2),
      .STAGES(2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_valid(cfg_valid),
      .cfg_mode (cfg_mode),
      .cfg_ready(cfg_ready),
      .mode     (mode),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .xfer_cnt (xfer_cnt)
   );

   always #5 clk = ~clk;

   // Hand-derived lane truth table, indexed by {mode, a1, a0}.
   function automatic logic [1:0] lane_ref(input logic [1:0] m, input logic [1:0] a);
      case ({m, a})
         4'h0: return 2'd0;  4'h1: return 2'd3;  4'h2: return 2'd2;  4'h3: return 2'd1;
         4'h4: return 2'd0;  4'h5: return 2'd2;  4'h6: return 2'd3;  4'h7: return 2'd1;
         4'h8: return 2'd0;  4'h9: return 2'd3;  4'hA: return 2'd1;  4'hB: return 2'd2;
         4'hC: return 2'd0;  4'hD: return 2'd1;  4'hE: return 2'd3;  4'hF: return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic [15:0] model(input logic [15:0] d, input logic [1:0] m);
      logic [15:0] r;
      r = '0;
      for (int l = 0; l < 8; l++) r[2*l +: 2] = lane_ref(m, d[2*l +: 2]);
      return r;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for out_valid with out_ready held high by the caller.
   task automatic get_out(output logic [15:0] d, output logic ok);
      ok = 1'b0;
      d  = '0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid === 1'b1) begin
            ok = 1'b1;
            d  = out_data;
            break;
         end
         cyc();
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
      total++; if (out_data !== 16'h0) begin bad++; $display("FAIL rst_out_data got=%h want=0000", out_data); end
      total++; if (mode !== 2'd0) begin bad++; $display("FAIL rst_mode got=%0d want=0", mode); end
      total++; if (xfer_cnt !== 16'h0) begin bad++; $display("FAIL rst_xfer_cnt got=%h want=0000", xfer_cnt); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
      total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL rst_cfg_ready got=%b want=0", cfg_ready); end
      cyc();
      cyc();
      rst_n = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got=%b want=1", in_ready); end
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL post_rst_cfg_ready got=%b want=1", cfg_ready); end
   endtask

   task automatic test_basic();
      cyc();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'hE4E4;
      cyc();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_lat1 got=%b want=0", out_valid); end
      cyc();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_lat2 got=%b want=1", out_valid); end
      total++; if (out_data !== 16'h6C6C) begin bad++; $display("FAIL basic_data got=%h want=6c6c", out_data); end
      cyc();
      total++; if (xfer_cnt !== 16'd1) begin bad++; $display("FAIL basic_xfer got=%h want=0001", xfer_cnt); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_drained got=%b want=0", out_valid); end
   endtask

   task automatic test_mode_sweep();
      logic [15:0] exp_tab [4];
      logic [15:0] d;
      logic        ok;
      exp_tab[0] = 16'h006C;
      exp_tab[1] = 16'h0078;
      exp_tab[2] = 16'h009C;
      exp_tab[3] = 16'h00B4;
      for (int m = 1; m < 4; m++) begin
         cfg_valid = 1'b1;
         cfg_mode  = 2'(m);
         in_valid  = 1'b0;
         #1;
         total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL sweep_cfg_ready m=%0d got=%b want=1", m, cfg_ready); end
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL sweep_in_ready_forced m=%0d got=%b want=0", m, in_ready); end
         cyc();
         cfg_valid = 1'b0;
         total++; if (mode !== 2'(m)) begin bad++; $display("FAIL sweep_mode got=%0d want=%0d", mode, m); end
         cur_mode = 2'(m);
         in_valid = 1'b1;
         in_data  = 16'h00E4;
         cyc();
         in_valid = 1'b0;
         get_out(d, ok);
         total++; if (!ok || d !== exp_tab[m]) begin bad++; $display("FAIL sweep_data m=%0d got=%h ok=%b want=%h", m, d, ok, exp_tab[m]); end
         total++; if (d[15:8] !== 8'h00) begin bad++; $display("FAIL sweep_share1 m=%0d got=%h want=00", m, d[15:8]); end
         cyc();
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] words [8];
      logic [15:0] held;
      logic [15:0] cnt0;
      logic        stalled_prev;
      logic        saw_drop;
      int          tx;
      int          rx;
      for (int i = 0; i < 8; i++) words[i] = 16'h1357 * 16'(i) + 16'h0F0F;
      cnt0 = xfer_cnt;
      tx = 0;
      rx = 0;
      stalled_prev = 1'b0;
      saw_drop = 1'b0;
      held = '0;
      for (int n = 0; n < 60 && rx < 8; n++) begin
         in_valid  = (tx < 8);
         in_data   = (tx < 8) ? words[tx] : 16'h0;
         out_ready = !(n >= 3 && n < 8);
         #1;
         if (stalled_prev) begin
            total++;
            if ({out_valid, out_data} !== {1'b1, held}) begin
               bad++; $display("FAIL b2b_stall_hold got=%b/%h want=1/%h", out_valid, out_data, held);
            end
         end
         if (out_valid && !out_ready) begin stalled_prev = 1'b1; held = out_data; end
         else stalled_prev = 1'b0;
         if (in_valid && !in_ready) saw_drop = 1'b1;
         if (out_valid && out_ready) begin
            total++;
            if (out_data !== model(words[rx], cur_mode)) begin
               bad++; $display("FAIL b2b_data idx=%0d got=%h want=%h", rx, out_data, model(words[rx], cur_mode));
            end
            rx++;
         end
         if (in_valid && in_ready) tx++;
         cyc();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      total++; if (rx != 8) begin bad++; $display("FAIL b2b_count got=%0d want=8", rx); end
      total++; if (saw_drop !== 1'b1) begin bad++; $display("FAIL b2b_in_ready_drop got=%b want=1", saw_drop); end
      total++; if (xfer_cnt - cnt0 !== 16'd8) begin bad++; $display("FAIL b2b_xfer got=%0d want=8", xfer_cnt - cnt0); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_no_dup got=%b want=0", out_valid); end
   endtask

   task automatic test_cfg_inflight();
      logic [15:0] words [2];
      logic [15:0] d;
      logic        ok;
      logic        done;
      int          got;
      words[0] = 16'hE4E4;
      words[1] = 16'h1B00;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = words[0];
      cyc();
      in_data = words[1];
      cyc();
      in_valid  = 1'b0;
      cfg_valid = 1'b1;
      cfg_mode  = 2'd2;
      #1;
      total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL inflight_cfg_held got=%b want=0", cfg_ready); end
      cyc();
      total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL inflight_cfg_held2 got=%b want=0", cfg_ready); end
      total++; if (mode !== 2'd3) begin bad++; $display("FAIL inflight_mode_kept got=%0d want=3", mode); end
      out_ready = 1'b1;
      got  = 0;
      done = 1'b0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (out_valid === 1'b1 && got < 2) begin
            total++;
            if (out_data !== model(words[got], 2'd3)) begin
               bad++; $display("FAIL inflight_old_mode idx=%0d got=%h want=%h", got, out_data, model(words[got], 2'd3));
            end
            got++;
         end
         if (cfg_ready === 1'b1) begin done = 1'b1; break; end
         cyc();
      end
      cyc();
      cfg_valid = 1'b0;
      total++; if (!done || got != 2) begin bad++; $display("FAIL inflight_drain got=%0d/%b want=2/1", got, done); end
      total++; if (mode !== 2'd2) begin bad++; $display("FAIL inflight_new_mode got=%0d want=2", mode); end
      cur_mode = 2'd2;
      in_valid = 1'b1;
      in_data  = 16'h00E4;
      cyc();
      in_valid = 1'b0;
      get_out(d, ok);
      total++; if (!ok || d !== 16'h009C) begin bad++; $display("FAIL inflight_next_word got=%h ok=%b want=009c", d, ok); end
      cyc();
   endtask

   task automatic test_reset_midstream();
      logic seen;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 16'hA5A5;
      cyc();
      in_data = 16'h3C3C;
      cyc();
      in_valid = 1'b0;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid got=%b want=1", out_valid); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
      total++; if (out_data !== 16'h0) begin bad++; $display("FAIL midrst_out_data got=%h want=0000", out_data); end
      total++; if (mode !== 2'd0) begin bad++; $display("FAIL midrst_mode got=%0d want=0", mode); end
      total++; if (xfer_cnt !== 16'h0) begin bad++; $display("FAIL midrst_xfer got=%h want=0000", xfer_cnt); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got=%b want=0", in_ready); end
      cyc();
      cyc();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      cur_mode  = 2'd0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_release_ready got=%b want=1", in_ready); end
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (out_valid !== 1'b0) seen = 1'b1;
         cyc();
      end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_stale_emit got=%b want=0", seen); end
   endtask

   task automatic test_wrap();
      logic reached;
      reached   = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'h0000;
      for (int i = 0; i < 70000; i++) begin
         cyc();
         if (xfer_cnt === 16'hFFFF) begin reached = 1'b1; break; end
      end
      total++; if (reached !== 1'b1) begin bad++; $display("FAIL wrap_reach got=%h want=ffff", xfer_cnt); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b want=1", out_valid); end
      cyc();
      in_valid = 1'b0;
      total++; if (xfer_cnt !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h want=0000", xfer_cnt); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mode_sweep();
      test_back_to_back();
      test_cfg_inflight();
      test_reset_midstream();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
